// File: rtl/microcode_sequencer.sv
// Purpose: steps a micro-step counter through a microcode ROM per opcode and returns finish/halt/jump to the driver.
// Latency: control word and finish are combinational from the registered {opcode, step}; halt and jump_flag are registered (+1 cycle).
// Backpressure: none. The driver paces the sequencer with load_n/enable, and rom_read_enable gates the word outputs.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 8,
    parameter int STEP_WIDTH   = 4,
    parameter int CW_WIDTH     = 32,
    parameter int FINISH_BIT   = 0,
    parameter int HALT_BIT     = 1,
    parameter int JUMP_BIT     = 2,
    parameter int JUMP_IF_BIT  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    condition_flag,
    input  logic                    microcode_sequencer_load_n,
    input  logic                    microcode_sequencer_enable,
    input  logic                    microcode_rom_read_enable,
    output logic [CW_WIDTH-1:0]     control_word,
    output logic                    instruction_finish_control_line,
    output logic                    halt,
    output logic                    jump_flag,
    output logic [STEP_WIDTH-1:0]   micro_step,
    output logic                    sequencer_fault
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, HALTED} state_t;

    localparam logic [STEP_WIDTH-1:0] STEP_MAX = '1;

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [STEP_WIDTH-1:0]   step;
    logic                    jump_fired;

    logic [CW_WIDTH-1:0]     rom_dat;
    logic                    word_vld;
    logic                    word_finish;
    logic                    word_halt;
    logic                    jump_take;

    // Microcode image, compiled in and addressed by {opcode, step}. Unlisted locations read as zero.
    function automatic logic [CW_WIDTH-1:0] rom_word(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [STEP_WIDTH-1:0]   st
    );
        logic [CW_WIDTH-1:0] w;
        w = '0;
        if (op == OPCODE_WIDTH'(8'h01) && st == STEP_WIDTH'(0)) begin
            w = CW_WIDTH'(32'h0100_0000);
            w[FINISH_BIT] = 1'b1;
        end else if (op == OPCODE_WIDTH'(8'h02)) begin
            if (st == STEP_WIDTH'(0)) w = CW_WIDTH'(32'h0200_0010);
            if (st == STEP_WIDTH'(1)) w = CW_WIDTH'(32'h0200_0020);
            if (st == STEP_WIDTH'(2)) begin
                w = CW_WIDTH'(32'h0200_0040);
                w[FINISH_BIT] = 1'b1;
            end
        end else if (op == OPCODE_WIDTH'(8'h03)) begin
            if (st == STEP_WIDTH'(0)) w = CW_WIDTH'(32'h0300_0010);
            if (st == STEP_WIDTH'(1)) begin
                w = CW_WIDTH'(32'h0300_0000);
                w[JUMP_IF_BIT] = 1'b1;
            end
            if (st == STEP_WIDTH'(2)) begin
                w = CW_WIDTH'(32'h0300_0000);
                w[FINISH_BIT] = 1'b1;
            end
        end else if (op == OPCODE_WIDTH'(8'h04)) begin
            // Deliberately never finishes, so it can exercise step overflow.
            w = CW_WIDTH'(32'h0400_0100);
        end else if (op == OPCODE_WIDTH'(8'hFF) && st == STEP_WIDTH'(0)) begin
            w = CW_WIDTH'(32'hFF00_0000);
            w[HALT_BIT] = 1'b1;
            w[JUMP_BIT] = 1'b1;
        end
        return w;
    endfunction

    // Gate the ROM word and decode the control bits that drive the next-state logic.
    always_comb begin
        rom_dat     = rom_word(opcode_q, step);
        word_vld    = microcode_rom_read_enable && (state != HALTED) && !reset;
        word_finish = word_vld && rom_dat[FINISH_BIT];
        word_halt   = word_vld && rom_dat[HALT_BIT];
        jump_take   = word_vld && !jump_fired
                      && (rom_dat[JUMP_BIT] || (rom_dat[JUMP_IF_BIT] && condition_flag));
        control_word                    = word_vld ? rom_dat : '0;
        instruction_finish_control_line = word_finish;
        micro_step                      = step;
    end

    // Sequencer FSM. Priority is reset > halt > load > finish > enable.
    // Halt is terminal until reset, and jump_fired limits each loaded instruction to one jump pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            opcode_q        <= '0;
            step            <= '0;
            halt            <= 1'b0;
            jump_flag       <= 1'b0;
            jump_fired      <= 1'b0;
            sequencer_fault <= 1'b0;
        end else begin
            jump_flag <= 1'b0;
            if (state != HALTED) begin
                if (word_halt) begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end else begin
                    if (jump_take) begin
                        jump_flag  <= 1'b1;
                        jump_fired <= 1'b1;
                    end
                    if (!microcode_sequencer_load_n) begin
                        state      <= RUN;
                        opcode_q   <= opcode;
                        step       <= '0;
                        jump_fired <= 1'b0;
                    end else if (state == RUN) begin
                        if (word_finish) begin
                            state <= DONE;
                        end else if (microcode_sequencer_enable) begin
                            // At the top step, flag the overflow and hold rather than wrap.
                            if (step == STEP_MAX) begin
                                sequencer_fault <= 1'b1;
                            end else begin
                                step <= step + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Purpose: self-checking bench for microcode_sequencer driven by a table of per-cycle stimulus rows.
// Latency: each row is driven, then checked 1 time unit after the following rising clock edge.
// Backpressure: not applicable. Expected values go into a scoreboard queue and are popped when checked.
module tb_microcode_sequencer;

    typedef struct {
        logic [31:0] cw;
        logic        fin;
        logic        hlt;
        logic        jmp;
        logic [3:0]  st;
        logic        flt;
    } exp_t;

    localparam logic [31:0] W01   = 32'h0100_0001;
    localparam logic [31:0] W02_0 = 32'h0200_0010;
    localparam logic [31:0] W02_1 = 32'h0200_0020;
    localparam logic [31:0] W02_2 = 32'h0200_0041;
    localparam logic [31:0] W03_0 = 32'h0300_0010;
    localparam logic [31:0] W03_1 = 32'h0300_0008;
    localparam logic [31:0] W03_2 = 32'h0300_0001;
    localparam logic [31:0] WFF   = 32'hFF00_0006;
    localparam logic [31:0] W04   = 32'h0400_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  opcode;
    logic        condition_flag;
    logic        load_n;
    logic        enable;
    logic        rd_en;
    logic [31:0] control_word;
    logic        finish;
    logic        halt;
    logic        jump_flag;
    logic [3:0]  micro_step;
    logic        sequencer_fault;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    microcode_sequencer dut (
        .clock                           (clock),
        .reset                           (reset),
        .opcode                          (opcode),
        .condition_flag                  (condition_flag),
        .microcode_sequencer_load_n      (load_n),
        .microcode_sequencer_enable      (enable),
        .microcode_rom_read_enable       (rd_en),
        .control_word                    (control_word),
        .instruction_finish_control_line (finish),
        .halt                            (halt),
        .jump_flag                       (jump_flag),
        .micro_step                      (micro_step),
        .sequencer_fault                 (sequencer_fault)
    );

    always #5 clock = ~clock;

    // Watchdog: stop the run if the stimulus never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then pop the queue and compare.
    task automatic cyc(input string tag,
                       input logic r, input logic ld, input logic en, input logic rd,
                       input logic cf, input logic [7:0] op,
                       input logic [31:0] cw, input logic fin, input logic hlt,
                       input logic jmp, input logic [3:0] st, input logic flt);
        exp_t e;
        exp_t got;
        reset          = r;
        load_n         = ld;
        enable         = en;
        rd_en          = rd;
        condition_flag = cf;
        opcode         = op;
        e.cw = cw; e.fin = fin; e.hlt = hlt; e.jmp = jmp; e.st = st; e.flt = flt;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({tag, ".cw"},    control_word,           got.cw);
            check({tag, ".fin"},   {31'd0, finish},          {31'd0, got.fin});
            check({tag, ".halt"},  {31'd0, halt},            {31'd0, got.hlt});
            check({tag, ".jump"},  {31'd0, jump_flag},       {31'd0, got.jmp});
            check({tag, ".step"},  {28'd0, micro_step},      {28'd0, got.st});
            check({tag, ".fault"}, {31'd0, sequencer_fault}, {31'd0, got.flt});
        end
    endtask

    initial begin
        reset = 1'b1; load_n = 1'b1; enable = 1'b1; rd_en = 1'b1;
        condition_flag = 1'b0; opcode = 8'h00;

        // Reset held with enable and read enable active: every output is zero.
        //   tag       r  ld en rd cf op     cw     fin hlt jmp st  flt
        cyc("rst0",    1, 1, 1, 1, 0, 8'h01, 32'd0, 0,  0,  0,  0,  0);
        cyc("rst1",    1, 1, 1, 1, 0, 8'h01, 32'd0, 0,  0,  0,  0,  0);
        cyc("idle",    0, 1, 1, 1, 0, 8'h00, 32'd0, 0,  0,  0,  0,  0);

        // One-step op 0x01: finish is visible right after the load edge, and the step stays at 0.
        cyc("op1.ld",  0, 0, 0, 1, 0, 8'h01, W01,   1,  0,  0,  0,  0);
        cyc("op1.en",  0, 1, 1, 1, 0, 8'h01, W01,   1,  0,  0,  0,  0);
        cyc("op1.dn",  0, 1, 1, 1, 0, 8'h01, W01,   1,  0,  0,  0,  0);
        cyc("op1.rd0", 0, 1, 1, 0, 0, 8'h01, 32'd0, 0,  0,  0,  0,  0);

        // Three-step op 0x02. Load wins over enable in the same cycle, and the step holds at 2 after finish.
        cyc("op2.ld",  0, 0, 1, 1, 0, 8'h02, W02_0, 0,  0,  0,  0,  0);
        cyc("op2.s1",  0, 1, 1, 1, 0, 8'h02, W02_1, 0,  0,  0,  1,  0);
        cyc("op2.s2",  0, 1, 1, 1, 0, 8'h02, W02_2, 1,  0,  0,  2,  0);
        cyc("op2.h1",  0, 1, 1, 1, 0, 8'h02, W02_2, 1,  0,  0,  2,  0);
        cyc("op2.h2",  0, 1, 1, 1, 0, 8'h02, W02_2, 1,  0,  0,  2,  0);

        // JUMP_IF at op 0x03 step 1 with the condition true: one pulse only, even while the word is held.
        cyc("op3.ld",  0, 0, 0, 1, 1, 8'h03, W03_0, 0,  0,  0,  0,  0);
        cyc("op3.s1",  0, 1, 1, 1, 1, 8'h03, W03_1, 0,  0,  0,  1,  0);
        cyc("op3.jp",  0, 1, 0, 1, 1, 8'h03, W03_1, 0,  0,  1,  1,  0);
        cyc("op3.nj1", 0, 1, 0, 1, 1, 8'h03, W03_1, 0,  0,  0,  1,  0);
        cyc("op3.nj2", 0, 1, 0, 1, 1, 8'h03, W03_1, 0,  0,  0,  1,  0);
        cyc("op3.s2",  0, 1, 1, 1, 1, 8'h03, W03_2, 1,  0,  0,  2,  0);
        // The same op with the condition false gives no pulse.
        cyc("op3c.ld", 0, 0, 0, 1, 0, 8'h03, W03_0, 0,  0,  0,  0,  0);
        cyc("op3c.s1", 0, 1, 1, 1, 0, 8'h03, W03_1, 0,  0,  0,  1,  0);
        cyc("op3c.w1", 0, 1, 0, 1, 0, 8'h03, W03_1, 0,  0,  0,  1,  0);
        cyc("op3c.w2", 0, 1, 0, 1, 0, 8'h03, W03_1, 0,  0,  0,  1,  0);

        // HALT and JUMP in one word: halt wins and stays set, later loads are ignored, and reset clears it.
        cyc("hlt.ld",  0, 0, 0, 1, 0, 8'hFF, WFF,   0,  0,  0,  0,  0);
        cyc("hlt.set", 0, 1, 0, 1, 0, 8'hFF, 32'd0, 0,  1,  0,  0,  0);
        cyc("hlt.ign", 0, 0, 1, 1, 0, 8'h01, 32'd0, 0,  1,  0,  0,  0);
        cyc("hlt.stk", 0, 1, 1, 1, 1, 8'h01, 32'd0, 0,  1,  0,  0,  0);
        cyc("hlt.rst", 1, 1, 0, 1, 0, 8'h00, 32'd0, 0,  0,  0,  0,  0);

        // Op 0x04 never finishes: the step saturates at 15 and the 16th enable sets the fault.
        cyc("ovf.ld",  0, 0, 0, 1, 0, 8'h04, W04,   0,  0,  0,  0,  0);
        for (int k = 1; k <= 15; k++) begin
            cyc($sformatf("ovf.e%0d", k), 0, 1, 1, 1, 0, 8'h04, W04, 0, 0, 0, 4'(k), 0);
        end
        cyc("ovf.e16", 0, 1, 1, 1, 0, 8'h04, W04,   0,  0,  0,  15, 1);
        cyc("ovf.e17", 0, 1, 1, 1, 0, 8'h04, W04,   0,  0,  0,  15, 1);
        // A mid-run reset returns the step to 0 and clears the fault.
        cyc("ovf.rst", 1, 1, 1, 1, 0, 8'h04, 32'd0, 0,  0,  0,  0,  0);
        cyc("ovf.rld", 0, 0, 0, 1, 0, 8'h04, W04,   0,  0,  0,  0,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
